// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the adder reservation station:
//   - instruction field positions (op / rd / rs / rt)
//   - NO_TAG, the tag value meaning "operand value already available"
//   - tag_of(), which maps a station entry index to the tag that entry owns
// ---------------------------------------------------------------------------
package rs_pkg;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;
  localparam int RD_MSB = 12;
  localparam int RD_LSB = 10;
  localparam int RS_MSB = 9;
  localparam int RS_LSB = 7;
  localparam int RT_MSB = 6;
  localparam int RT_LSB = 4;

  localparam int NO_TAG = 0;

  // Entry i owns tag base+i; base is chosen so that no entry owns NO_TAG.
  function automatic int unsigned tag_of(input int unsigned index, input int unsigned base);
    return base + index;
  endfunction

endpackage

// File: rtl/rs_priority_sel.sv
// ---------------------------------------------------------------------------
// rs_priority_sel
// Finds the lowest set bit of a request vector.
// Ports:
//   req     in   N      request vector
//   onehot  out  N      one-hot mask of the lowest set request (0 if none)
//   idx     out  IDX_W  index of the lowest set request (0 if none)
//   any     out  1      at least one request is set
// ---------------------------------------------------------------------------
module rs_priority_sel #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set request is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rs_adders_param.sv
// ---------------------------------------------------------------------------
// rs_adders_param
// Parametrised reservation station for the adder unit of the Tomasulo core,
// with an integrated register-status table. Takes one issued instruction per
// cycle, captures operand values or producer tags, snoops the CDB to wake
// waiting entries, dispatches ready entries to the adder through a registered
// valid/ready handshake and frees an entry when its own tag appears on the CDB.
// Ports:
//   Clock        in   1       system clock, rising edge
//   Resetn       in   1       asynchronous active-low reset
//   issue_valid  in   1       instruction offered by the issue unit
//   issue_ready  out  1       at least one entry free
//   instruction  in   16      [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt
//   rs_value     in   DATA_W  register-file value of rs
//   rt_value     in   DATA_W  register-file value of rt
//   cdb_valid    in   1       CDB broadcast this cycle
//   cdb_tag      in   TAG_W   producer tag on the CDB
//   cdb_value    in   DATA_W  result on the CDB
//   exec_valid   out  1       dispatched entry offered to the adder
//   exec_ready   in   1       adder accepts
//   exec_op      out  3       opcode of the dispatched entry
//   exec_vj      out  DATA_W  first operand
//   exec_vk      out  DATA_W  second operand
//   exec_tag     out  TAG_W   tag the adder returns on the CDB
//   Busy         out  DEPTH   per-entry occupancy
// ---------------------------------------------------------------------------
module rs_adders_param
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned TAG_BASE = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [15:0]       instruction,
  input  logic [DATA_W-1:0] rs_value,
  input  logic [DATA_W-1:0] rt_value,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              exec_valid,
  input  logic              exec_ready,
  output logic [2:0]        exec_op,
  output logic [DATA_W-1:0] exec_vj,
  output logic [DATA_W-1:0] exec_vk,
  output logic [TAG_W-1:0]  exec_tag,
  output logic [DEPTH-1:0]  Busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned REG_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(NO_TAG);

  // Per-entry state
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  disp_q;
  logic [2:0]        op_q [DEPTH];
  logic [TAG_W-1:0]  qj_q [DEPTH];
  logic [TAG_W-1:0]  qk_q [DEPTH];
  logic [DATA_W-1:0] vj_q [DEPTH];
  logic [DATA_W-1:0] vk_q [DEPTH];

  // Register-status table: tag of the pending producer, or NO_TAG
  logic [TAG_W-1:0]  regstat_q [NREGS];

  logic [TAG_W-1:0]  entry_tag [DEPTH];
  logic [IDX_W-1:0]  exec_idx_q;

  // Instruction decode
  logic [2:0]        op_f;
  logic [REG_W-1:0]  rd_f;
  logic [REG_W-1:0]  rs_f;
  logic [REG_W-1:0]  rt_f;
  logic              unused_instr_bits;

  assign op_f = instruction[OP_MSB:OP_LSB];
  assign rd_f = instruction[RD_LSB +: REG_W];
  assign rs_f = instruction[RS_LSB +: REG_W];
  assign rt_f = instruction[RT_LSB +: REG_W];
  assign unused_instr_bits = ^instruction[3:0];

  // Tag 0 on the CDB can never name a producer, so it must not wake
  // operands that already hold a value (Q == NO_TAG).
  logic cdb_hit;
  assign cdb_hit = cdb_valid & (cdb_tag != TAG_NONE);

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_tag[i] = TAG_W'(tag_of(i, TAG_BASE));
    end
  end

  // Allocation: lowest free entry. issue_ready depends only on the Busy bits
  // before the edge, so an entry freed by the CDB this cycle is not reused yet.
  logic [DEPTH-1:0] alloc_onehot;
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_any;
  logic             do_issue;
  logic [TAG_W-1:0] alloc_tag;

  rs_priority_sel #(.N(DEPTH), .IDX_W(IDX_W)) u_alloc_sel (
    .req    (~busy_q),
    .onehot (alloc_onehot),
    .idx    (alloc_idx),
    .any    (alloc_any)
  );

  assign issue_ready = alloc_any;
  assign do_issue    = issue_valid & alloc_any;
  assign alloc_tag   = entry_tag[alloc_idx];

  // Source operand resolution at issue: value from the register file, value
  // forwarded from a same-cycle CDB broadcast, or the producer's tag.
  function automatic logic [TAG_W+DATA_W-1:0] resolve_src(
    input logic [TAG_W-1:0]  stat,
    input logic [DATA_W-1:0] rf_val,
    input logic              hit,
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] val
  );
    if (stat == TAG_NONE)     return {TAG_NONE, rf_val};
    else if (hit && stat == tag) return {TAG_NONE, val};
    else                      return {stat, rf_val};
  endfunction

  logic [TAG_W-1:0]  src_j_q, src_k_q;
  logic [DATA_W-1:0] src_j_v, src_k_v;

  assign {src_j_q, src_j_v} = resolve_src(regstat_q[rs_f], rs_value, cdb_hit, cdb_tag, cdb_value);
  assign {src_k_q, src_k_v} = resolve_src(regstat_q[rt_f], rt_value, cdb_hit, cdb_tag, cdb_value);

  // Dispatch candidates: busy, not yet dispatched, both operands present.
  // The entry already sitting in the exec register is excluded so the next
  // candidate can be loaded on the same edge it is accepted.
  logic [DEPTH-1:0] disp_req;
  logic [DEPTH-1:0] unused_disp_onehot;
  logic [IDX_W-1:0] disp_idx;
  logic             disp_any;
  logic             accept;

  always_comb begin
    disp_req = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      disp_req[i] = busy_q[i] & ~disp_q[i] & (qj_q[i] == TAG_NONE) & (qk_q[i] == TAG_NONE)
                    & ~(exec_valid & (exec_idx_q == IDX_W'(i)));
    end
  end

  rs_priority_sel #(.N(DEPTH), .IDX_W(IDX_W)) u_disp_sel (
    .req    (disp_req),
    .onehot (unused_disp_onehot),
    .idx    (disp_idx),
    .any    (disp_any)
  );

  assign accept = exec_valid & exec_ready;

  // Exec register: loads a new candidate when empty or when the current one
  // is accepted; otherwise it holds so the adder sees stable operands.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      exec_valid <= 1'b0;
      exec_op    <= '0;
      exec_vj    <= '0;
      exec_vk    <= '0;
      exec_tag   <= TAG_NONE;
      exec_idx_q <= '0;
    end else if (!exec_valid || exec_ready) begin
      exec_valid <= disp_any;
      if (disp_any) begin
        exec_op    <= op_q[disp_idx];
        exec_vj    <= vj_q[disp_idx];
        exec_vk    <= vk_q[disp_idx];
        exec_tag   <= entry_tag[disp_idx];
        exec_idx_q <= disp_idx;
      end
    end
  end

  // Entry update: CDB wakeup and free, dispatch acknowledge, then issue.
  // Issue only targets an entry that was free, so it never collides with
  // the wakeup/free of a busy entry.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      busy_q <= '0;
      disp_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        op_q[i] <= '0;
        qj_q[i] <= TAG_NONE;
        qk_q[i] <= TAG_NONE;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (cdb_hit && busy_q[i]) begin
          if (qj_q[i] == cdb_tag) begin
            qj_q[i] <= TAG_NONE;
            vj_q[i] <= cdb_value;
          end
          if (qk_q[i] == cdb_tag) begin
            qk_q[i] <= TAG_NONE;
            vk_q[i] <= cdb_value;
          end
          if (entry_tag[i] == cdb_tag) begin
            busy_q[i] <= 1'b0;
            disp_q[i] <= 1'b0;
          end
        end
        if (accept && (exec_idx_q == IDX_W'(i))) begin
          disp_q[i] <= 1'b1;
        end
        if (do_issue && alloc_onehot[i]) begin
          busy_q[i] <= 1'b1;
          disp_q[i] <= 1'b0;
          op_q[i]   <= op_f;
          qj_q[i]   <= src_j_q;
          qk_q[i]   <= src_k_q;
          vj_q[i]   <= src_j_v;
          vk_q[i]   <= src_k_v;
        end
      end
    end
  end

  // Register status: a same-cycle issue to rd overrides the CDB clear, so a
  // newer producer of the register is never forgotten.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regstat_q[r] <= TAG_NONE;
      end
    end else begin
      for (int r = 0; r < int'(NREGS); r++) begin
        if (do_issue && (rd_f == REG_W'(r))) begin
          regstat_q[r] <= alloc_tag;
        end else if (cdb_hit && (regstat_q[r] == cdb_tag)) begin
          regstat_q[r] <= TAG_NONE;
        end
      end
    end
  end

  assign Busy = busy_q;

endmodule

// File: tb/tb_rs_adders_param.sv
// ---------------------------------------------------------------------------
// tb_rs_adders_param
// Self-checking bench for rs_adders_param: directed scenarios followed by a
// randomized run, all outputs compared each cycle against a behavioural
// model of the station kept in the bench.
// ---------------------------------------------------------------------------
module tb_rs_adders_param;

  localparam int DEPTH    = 8;
  localparam int DATA_W   = 16;
  localparam int NREGS    = 8;
  localparam int TAG_W    = 4;
  localparam int TAG_BASE = 1;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_ready;
  logic [15:0]       instruction = '0;
  logic [DATA_W-1:0] rs_value = '0;
  logic [DATA_W-1:0] rt_value = '0;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_value = '0;
  logic              exec_valid;
  logic              exec_ready = 1'b0;
  logic [2:0]        exec_op;
  logic [DATA_W-1:0] exec_vj;
  logic [DATA_W-1:0] exec_vk;
  logic [TAG_W-1:0]  exec_tag;
  logic [DEPTH-1:0]  Busy;

  rs_adders_param #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .NREGS(NREGS), .TAG_W(TAG_W), .TAG_BASE(TAG_BASE)
  ) dut (
    .Clock(Clock), .Resetn(Resetn),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .instruction(instruction),
    .rs_value(rs_value), .rt_value(rt_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_op(exec_op),
    .exec_vj(exec_vj), .exec_vk(exec_vk), .exec_tag(exec_tag), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Reference model: the station as a table of entries plus the register
  // status table and the single instruction currently offered to the adder.
  typedef struct packed {
    logic              busy;
    logic              disp;
    logic [2:0]        op;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
  } ent_t;

  ent_t              ent [DEPTH];
  logic [TAG_W-1:0]  rstat [NREGS];
  logic              m_valid;
  int                m_entry;
  logic [2:0]        m_op;
  logic [DATA_W-1:0] m_vj, m_vk;
  logic [TAG_W-1:0]  m_tag;
  logic [TAG_W-1:0]  pending [$];

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int rt);
    return {op[2:0], rd[2:0], rs[2:0], rt[2:0], 4'b0000};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) ent[i] = '0;
    for (int r = 0; r < NREGS; r++) rstat[r] = '0;
    m_valid = 1'b0;
    m_entry = 0;
    m_op = '0; m_vj = '0; m_vk = '0; m_tag = '0;
    pending.delete();
  endtask

  // One clock edge of the model, from the inputs currently applied.
  task automatic modelStep();
    ent_t             old [DEPTH];
    logic [TAG_W-1:0] ors [NREGS];
    logic [TAG_W-1:0] prod;
    int               fr, cand;
    logic             hit, iss;
    old = ent;
    ors = rstat;
    hit = cdb_valid && (cdb_tag != 0);
    fr = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!old[i].busy) fr = i;
    iss = issue_valid && (fr >= 0);
    cand = -1;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (old[i].busy && !old[i].disp && old[i].qj == 0 && old[i].qk == 0 && !(m_valid && m_entry == i))
        cand = i;
    if (hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (old[i].busy) begin
          if (old[i].qj == cdb_tag) begin ent[i].qj = 0; ent[i].vj = cdb_value; end
          if (old[i].qk == cdb_tag) begin ent[i].qk = 0; ent[i].vk = cdb_value; end
          if (TAG_W'(i + TAG_BASE) == cdb_tag) begin ent[i].busy = 0; ent[i].disp = 0; end
        end
      end
    end
    if (m_valid && exec_ready) begin
      ent[m_entry].disp = 1'b1;
      pending.push_back(m_tag);
    end
    if (!m_valid || exec_ready) begin
      m_valid = (cand >= 0);
      if (cand >= 0) begin
        m_entry = cand;
        m_op    = old[cand].op;
        m_vj    = old[cand].vj;
        m_vk    = old[cand].vk;
        m_tag   = TAG_W'(cand + TAG_BASE);
      end
    end
    if (iss) begin
      ent[fr].busy = 1'b1;
      ent[fr].disp = 1'b0;
      ent[fr].op   = instruction[15:13];
      prod = ors[instruction[9:7]];
      ent[fr].qj = (prod == 0 || (hit && prod == cdb_tag)) ? '0 : prod;
      ent[fr].vj = (prod == 0) ? rs_value : cdb_value;
      prod = ors[instruction[6:4]];
      ent[fr].qk = (prod == 0 || (hit && prod == cdb_tag)) ? '0 : prod;
      ent[fr].vk = (prod == 0) ? rt_value : cdb_value;
    end
    for (int r = 0; r < NREGS; r++) if (hit && ors[r] == cdb_tag) rstat[r] = '0;
    if (iss) rstat[instruction[12:10]] = TAG_W'(fr + TAG_BASE);
  endtask

  task automatic compareAll();
    logic [DEPTH-1:0] eb;
    eb = '0;
    for (int i = 0; i < DEPTH; i++) eb[i] = ent[i].busy;
    checkOutput("busy", Busy, eb);
    checkOutput("issue_ready", issue_ready, ~&eb);
    checkOutput("exec_valid", exec_valid, m_valid);
    if (m_valid) begin
      checkOutput("exec_op", exec_op, m_op);
      checkOutput("exec_vj", exec_vj, m_vj);
      checkOutput("exec_vk", exec_vk, m_vk);
      checkOutput("exec_tag", exec_tag, m_tag);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, and compare at the next falling edge.
  task automatic applyStimulus(input logic iv, input logic [15:0] ins,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic cv, input int ct, input logic [DATA_W-1:0] cval,
                               input logic er);
    issue_valid = iv;
    instruction = ins;
    rs_value    = a;
    rt_value    = b;
    cdb_valid   = cv;
    cdb_tag     = TAG_W'(ct);
    cdb_value   = cval;
    exec_ready  = er;
    @(posedge Clock);
    modelStep();
    @(negedge Clock);
    compareAll();
  endtask

  task automatic idle(input logic er);
    applyStimulus(1'b0, 16'h0, '0, '0, 1'b0, 0, '0, er);
  endtask

  task automatic doReset();
    @(negedge Clock);
    Resetn = 1'b0;
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
    exec_ready = 1'b0;
    modelReset();
    @(negedge Clock);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_exec_valid", exec_valid, 0);
    checkOutput("rst_issue_ready", issue_ready, 1);
    Resetn = 1'b1;
  endtask

  // Run accepting cycles until the given tag is offered, then check its vj.
  task automatic waitTag(input int tag, input int vj_exp, input string name);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 30) begin
      if (exec_valid && exec_tag == TAG_W'(tag)) seen = 1'b1;
      else begin
        idle(1'b1);
        n++;
      end
    end
    checkOutput({name, "_seen"}, seen, 1);
    if (seen) checkOutput({name, "_vj"}, exec_vj, vj_exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic iv, cv, er;
    int   ct, k;

    modelReset();
    doReset();

    // Simple issue and dispatch, then a RAW dependence woken by the CDB
    applyStimulus(1'b1, mk(0, 1, 2, 3), 16'd5, 16'd7, 1'b0, 0, '0, 1'b1);
    checkOutput("t1_busy", Busy, 8'h01);
    checkOutput("t1_not_yet", exec_valid, 0);
    applyStimulus(1'b1, mk(0, 4, 1, 2), 16'd100, 16'd3, 1'b0, 0, '0, 1'b1);
    checkOutput("t1_valid", exec_valid, 1);
    checkOutput("t1_vj", exec_vj, 5);
    checkOutput("t1_vk", exec_vk, 7);
    checkOutput("t1_tag", exec_tag, 1);
    idle(1'b1);
    applyStimulus(1'b0, 16'h0, '0, '0, 1'b1, 1, 16'd12, 1'b1);
    checkOutput("raw_wait", exec_valid, 0);
    idle(1'b1);
    checkOutput("raw_valid", exec_valid, 1);
    checkOutput("raw_vj", exec_vj, 12);
    checkOutput("raw_tag", exec_tag, 2);

    // Same-cycle bypass: r2 produced by tag 3, broadcast while r5=r2+r0 issues
    doReset();
    applyStimulus(1'b1, mk(1, 6, 0, 0), 16'd1, 16'd1, 1'b0, 0, '0, 1'b0);
    applyStimulus(1'b1, mk(1, 7, 0, 0), 16'd1, 16'd1, 1'b0, 0, '0, 1'b0);
    applyStimulus(1'b1, mk(1, 2, 0, 0), 16'd1, 16'd1, 1'b0, 0, '0, 1'b0);
    applyStimulus(1'b1, mk(2, 5, 2, 0), 16'd100, 16'd0, 1'b1, 3, 16'd9, 1'b0);
    applyStimulus(1'b1, mk(3, 6, 2, 2), 16'd50, 16'd60, 1'b0, 0, '0, 1'b0);
    waitTag(3, 50, "regstat_cleared");
    waitTag(4, 9, "bypass");

    // Issue wins over a same-cycle CDB clear of the destination register
    doReset();
    applyStimulus(1'b1, mk(0, 3, 0, 0), 16'd2, 16'd2, 1'b0, 0, '0, 1'b1);
    applyStimulus(1'b1, mk(0, 1, 0, 0), 16'd2, 16'd2, 1'b0, 0, '0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    applyStimulus(1'b1, mk(0, 1, 0, 0), 16'd2, 16'd2, 1'b1, 2, 16'd77, 1'b1);
    applyStimulus(1'b1, mk(0, 4, 1, 0), 16'd999, 16'd4, 1'b0, 0, '0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    applyStimulus(1'b0, 16'h0, '0, '0, 1'b1, 3, 16'd55, 1'b1);
    waitTag(2, 55, "issue_wins");

    // Full station: ninth issue ignored, freed entry reused the cycle after
    doReset();
    applyStimulus(1'b1, mk(0, 1, 0, 0), 16'd1, 16'd1, 1'b0, 0, '0, 1'b1);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, mk(i, 2, 1, 1), 16'd0, 16'd0, 1'b0, 0, '0, 1'b1);
    checkOutput("full_busy", Busy, 8'hFF);
    checkOutput("full_ready", issue_ready, 0);
    applyStimulus(1'b1, mk(0, 3, 0, 0), 16'd8, 16'd8, 1'b0, 0, '0, 1'b0);
    checkOutput("full_ignored", Busy, 8'hFF);
    applyStimulus(1'b0, 16'h0, '0, '0, 1'b1, 1, 16'd4, 1'b0);
    checkOutput("free_busy", Busy, 8'hFE);
    checkOutput("free_ready", issue_ready, 1);
    applyStimulus(1'b1, mk(1, 5, 0, 0), 16'd3, 16'd3, 1'b0, 0, '0, 1'b0);
    checkOutput("reuse_busy", Busy, 8'hFF);

    // Backpressure: exec outputs hold, then consecutive dispatches on release
    doReset();
    applyStimulus(1'b1, mk(0, 1, 2, 3), 16'd11, 16'd22, 1'b0, 0, '0, 1'b0);
    applyStimulus(1'b1, mk(0, 2, 4, 5), 16'd33, 16'd44, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checkOutput("bp_hold_tag", exec_tag, 1);
      checkOutput("bp_hold_vj", exec_vj, 11);
    end
    idle(1'b1);
    checkOutput("bp_next_valid", exec_valid, 1);
    checkOutput("bp_next_tag", exec_tag, 2);
    checkOutput("bp_next_vk", exec_vk, 44);
    idle(1'b1);
    checkOutput("bp_drained", exec_valid, 0);

    // Asynchronous reset pulse in the middle of a dispatch
    applyStimulus(1'b1, mk(0, 1, 0, 0), 16'd6, 16'd6, 1'b0, 0, '0, 1'b0);
    applyStimulus(1'b1, mk(0, 2, 0, 0), 16'd6, 16'd6, 1'b0, 0, '0, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    checkOutput("async_exec_valid", exec_valid, 0);
    checkOutput("async_busy", Busy, 0);
    checkOutput("async_issue_ready", issue_ready, 1);
    modelReset();
    @(negedge Clock);
    Resetn = 1'b1;
    compareAll();

    // Randomized traffic; the CDB only returns tags the adder has accepted,
    // or tags that match no entry.
    for (int c = 0; c < 600; c++) begin
      iv = ($urandom_range(0, 2) != 0);
      er = ($urandom_range(0, 3) != 0);
      cv = 1'b0;
      ct = 0;
      if (pending.size() > 0 && $urandom_range(0, 2) == 0) begin
        k  = $urandom_range(0, pending.size() - 1);
        ct = int'(pending[k]);
        pending.delete(k);
        cv = 1'b1;
      end else if ($urandom_range(0, 9) == 0) begin
        cv = 1'b1;
        ct = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + TAG_BASE, 15);
      end
      applyStimulus(iv, mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                    DATA_W'($urandom), DATA_W'($urandom), cv, ct, DATA_W'($urandom), er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rs_adders_param.md
Name: rs_adders_param

Overview:
Parametrised reservation station for the adder functional unit of the Tomasulo core, with an integrated register-status table. Accepts one issued instruction per cycle, captures operand values or producer tags, and snoops the common data bus (CDB) to wake dependent entries. Dispatches ready entries to the adder through a valid/ready handshake and frees each entry when its own result appears on the CDB. Sits between the issue unit and the adder and replaces the fixed 7-entry tag-only station.

Parameters:
DEPTH, 8, number of station entries (1..15).
DATA_W, 16, operand/result width.
NREGS, 8, architectural registers; the register-index width is clog2(NREGS).
TAG_W, 4, tag width; tag 0 = "value available", entry i owns tag TAG_BASE+i.
TAG_BASE, 1, tag of entry 0; all DEPTH tags must be nonzero and fit in TAG_W.

Ports:
Clock  in  1  single system clock, rising edge.
Resetn  in  1  asynchronous, active-low reset.
issue_valid  in  1  new instruction offered.
issue_ready  out  1  at least one entry free (combinational from Busy).
instruction  in  16  [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt.
rs_value  in  DATA_W  register-file value of rs (valid when issue_valid).
rt_value  in  DATA_W  register-file value of rt.
cdb_valid  in  1  CDB broadcast this cycle.
cdb_tag  in  TAG_W  producer tag on CDB.
cdb_value  in  DATA_W  result on CDB.
exec_valid  out  1  an entry is dispatched to the adder.
exec_ready  in  1  adder accepts.
exec_op  out  3  opcode of the dispatched entry.
exec_vj  out  DATA_W  first operand.
exec_vk  out  DATA_W  second operand.
exec_tag  out  TAG_W  tag the adder must return on the CDB.
Busy  out  DEPTH  per-entry occupancy.

Behaviour:
- Reset (async, Resetn=0): Busy=0, all dispatched flags=0, all Qj/Qk=0, all register-status entries=0, exec_valid=0. issue_ready=1 after reset.
- Per-entry state: Busy, Dispatched, Op, Qj, Qk, Vj, Vk.
- Issue (issue_valid & issue_ready, at the rising clock edge): allocate the lowest-index entry with Busy=0. Op=instruction[15:13].
  - Operand capture for rs: if regstat[rs]==0, Qj=0 and Vj=rs_value.
  - Otherwise, if cdb_valid and cdb_tag==regstat[rs] in the same cycle, Qj=0 and Vj=cdb_value (bypass).
  - Otherwise Qj=regstat[rs].
  - rt/Qk/Vk follow the same rules.
  - regstat[rd] is set to the tag of the allocated entry.
  - rd==rs or rd==rt: operands read the status from before the update.
- Issue with issue_ready=0 is ignored; no state changes.
- CDB snoop (cdb_valid): every busy entry with Qj==cdb_tag loads Vj=cdb_value and sets Qj=0; the same applies to Qk.
  - Every register with regstat==cdb_tag is cleared to 0, unless that register is the rd of a same-cycle issue; issue wins.
  - The entry whose tag==cdb_tag clears Busy and Dispatched.
  - A freed entry is not reallocated in the same cycle; issue_ready reflects Busy from before the edge.
- Dispatch:
  - Candidate = lowest-index entry with Busy & ~Dispatched & Qj==0 & Qk==0.
  - exec_* outputs are registered. Once exec_valid=1, exec_op, exec_vj, exec_vk and exec_tag hold stable until exec_valid & exec_ready.
  - On accept, that entry sets Dispatched=1. exec_valid updates at the same edge to the next candidate, or 0 if none.
  - Back-to-back dispatch is one per cycle.
  - Latency: an entry issued with both operands available can be dispatched with exec_valid at edge+1 after issue.
  - An entry woken by the CDB at edge T is eligible at edge T+1.
- A CDB tag matching no entry and no register is a no-op.
- Resetn asserted mid-operation clears everything, including in-flight dispatch; the adder must be reset alongside.

Decomposition:
- Shared package rs_pkg: instruction field positions (OP_MSB/LSB, RD, RS, RT), the NO_TAG=0 constant, and a function tag_of(index).
- One natural sub-module: rs_priority_sel (DEPTH-bit request vector -> one-hot/index of the lowest set bit plus an any flag). It is used for both allocation and dispatch selection.

Test Plan:
- After reset: issue ADD r1=r2+r3 with rs_value=5, rt_value=7 and exec_ready=1 -> exec_valid at the next edge, exec_vj=5, exec_vk=7, exec_tag=1, Busy=8'b00000001.
- RAW dependence: issue r1=r2+r3, then r4=r1+r2 -> entry 1 holds Qj=1; CDB tag=1, value=12 -> entry 1 dispatches one cycle later with vj=12.
- Same-cycle bypass: regstat[r2]=3 and issue r5=r2+r0 while cdb_tag=3, value=9 -> the new entry has Qj=0, Vj=9; regstat[r2]=0.
- WAW/issue-wins: the CDB clears tag 2 for r1 in the same cycle as a new issue writing r1 -> regstat[r1]=the new tag, not 0.
- Full: fill DEPTH=8 with exec_ready=0 -> issue_ready=0 and a 9th issue is ignored; CDB tag=1 frees entry 0 -> issue_ready=1 next cycle and the following issue takes entry 0.
- Backpressure: exec_ready low for 3 cycles with 2 entries ready -> exec outputs stay stable; on release, tags 1 then 2 dispatch on consecutive cycles; an async Resetn pulse mid-run -> all outputs return to their reset values immediately.
